// File: rtl/proc_control_unit_pkg.sv
// Shared constants for the 9-bit processor control unit: opcodes, time steps
// and the AddSub encoding.
package proc_control_unit_pkg;

  localparam int unsigned INSTR_W = 9;
  localparam int unsigned FIELD_W = 3;
  localparam int unsigned REG_N   = 8;
  localparam int unsigned STEP_W  = 2;

  localparam logic [FIELD_W-1:0] OP_MV  = 3'b000;
  localparam logic [FIELD_W-1:0] OP_MVI = 3'b001;
  localparam logic [FIELD_W-1:0] OP_ADD = 3'b010;
  localparam logic [FIELD_W-1:0] OP_SUB = 3'b011;

  localparam logic ADDSUB_ADD = 1'b0;
  localparam logic ADDSUB_SUB = 1'b1;

  typedef enum logic [STEP_W-1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

  // True for the two three-step ALU instructions.
  function automatic logic is_alu_op(input logic [FIELD_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/decode3_8bits.sv
// 3-to-8 register field decoder. Code 000 selects bit 7, code 111 bit 0.
// Ports: W (field code), En (enable), Y (one-hot select, all 0 when !En).
module decode3_8bits (
  input  logic [2:0] W,
  input  logic       En,
  output logic [7:0] Y
);

  assign Y = En ? (8'h80 >> W) : 8'h00;

endmodule

// File: rtl/proc_control_unit_upcount2.sv
// 2-bit time-step counter.
// Ports: Clock, Reset (async, active-high), Clear (sync, wins over En),
// En (increment enable), Q (count).
module upcount2 (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Clear,
  input  logic       En,
  output logic [1:0] Q
);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)      Q <= 2'd0;
    else if (Clear) Q <= 2'd0;
    else if (En)    Q <= Q + 2'd1;
  end

endmodule

// File: rtl/proc_control_unit.sv
// Instruction sequencer for the 9-bit simple processor. Fetches IIIXXXYYY
// from DIN in T0 and sequences mv / mvi / add / sub over the shared bus.
// Ports: Clock, Reset (async, active-high), Run (start, sampled in T0),
// DIN (instruction / immediate); outputs IRin, Rin/Rout (one-hot, bit 7 = R0),
// DINout, Ain, Gin, Gout, AddSub, Done (combinational from step, IR, Run),
// Tstep (current step).
module proc_control_unit
  import proc_control_unit_pkg::*;
(
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Run,
  input  logic [INSTR_W-1:0] DIN,
  output logic               IRin,
  output logic [REG_N-1:0]   Rin,
  output logic [REG_N-1:0]   Rout,
  output logic               DINout,
  output logic               Ain,
  output logic               Gin,
  output logic               Gout,
  output logic               AddSub,
  output logic               Done,
  output logic [STEP_W-1:0]  Tstep
);

  logic [INSTR_W-1:0] ir;
  logic [FIELD_W-1:0] op;
  logic [REG_N-1:0]   x_oh;
  logic [REG_N-1:0]   y_oh;
  logic               step_clr;
  logic               step_inc;
  step_t              step;

  assign op   = ir[8:6];
  assign step = step_t'(Tstep);

  // Instruction register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)     ir <= '0;
    else if (IRin) ir <= DIN;
  end

  decode3_8bits u_dec_x (.W(ir[5:3]), .En(1'b1), .Y(x_oh));
  decode3_8bits u_dec_y (.W(ir[2:0]), .En(1'b1), .Y(y_oh));

  upcount2 u_step (
    .Clock (Clock),
    .Reset (Reset),
    .Clear (step_clr),
    .En    (step_inc),
    .Q     (Tstep)
  );

  // Per-step control decode. Reset gates everything so outputs drop
  // asynchronously even mid-instruction.
  always_comb begin
    IRin     = 1'b0;
    Rin      = '0;
    Rout     = '0;
    DINout   = 1'b0;
    Ain      = 1'b0;
    Gin      = 1'b0;
    Gout     = 1'b0;
    AddSub   = ADDSUB_ADD;
    Done     = 1'b0;
    step_clr = 1'b0;
    step_inc = 1'b0;
    if (!Reset) begin
      unique case (step)
        T0: begin
          IRin     = Run;
          step_inc = Run;
        end
        T1: begin
          if (op == OP_MV) begin
            Rout = y_oh;
            Rin  = x_oh;
            Done = 1'b1;
          end else if (op == OP_MVI) begin
            DINout = 1'b1;
            Rin    = x_oh;
            Done   = 1'b1;
          end else if (is_alu_op(op)) begin
            Rout = x_oh;
            Ain  = 1'b1;
          end else begin
            Done = 1'b1;
          end
          step_inc = is_alu_op(op);
          step_clr = !is_alu_op(op);
        end
        T2: begin
          // A non-ALU opcode here is unreachable; fall back to T0 quietly.
          if (is_alu_op(op)) begin
            Rout     = y_oh;
            Gin      = 1'b1;
            AddSub   = (op == OP_SUB) ? ADDSUB_SUB : ADDSUB_ADD;
            step_inc = 1'b1;
          end else begin
            step_clr = 1'b1;
          end
        end
        T3: begin
          if (is_alu_op(op)) begin
            Gout = 1'b1;
            Rin  = x_oh;
            Done = 1'b1;
          end
          step_clr = 1'b1;
        end
        default: step_clr = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_control_unit.sv
// Self-checking bench for proc_control_unit: reset behaviour, a directed
// cycle table, a mid-instruction reset sequence and randomized traffic
// against a micro-op-list reference model.
module tb_proc_control_unit;

  logic       Clock;
  logic       Reset;
  logic       Run;
  logic [8:0] DIN;
  logic       IRin;
  logic [7:0] Rin;
  logic [7:0] Rout;
  logic       DINout;
  logic       Ain;
  logic       Gin;
  logic       Gout;
  logic       AddSub;
  logic       Done;
  logic [1:0] Tstep;

  proc_control_unit dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Run    (Run),
    .DIN    (DIN),
    .IRin   (IRin),
    .Rin    (Rin),
    .Rout   (Rout),
    .DINout (DINout),
    .Ain    (Ain),
    .Gin    (Gin),
    .Gout   (Gout),
    .AddSub (AddSub),
    .Done   (Done),
    .Tstep  (Tstep)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic       irin;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       dinout;
    logic       ain;
    logic       gin;
    logic       gout;
    logic       addsub;
    logic       done;
    logic [1:0] tstep;
  } obs_t;

  typedef struct {
    logic       run;
    logic [8:0] din;
    obs_t       exp;
    string      name;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  obs_t plan[$];

  function automatic obs_t mk(input logic irin, input logic [7:0] rin,
                              input logic [7:0] rout, input logic dinout,
                              input logic ain, input logic gin, input logic gout,
                              input logic addsub, input logic done,
                              input logic [1:0] t);
    obs_t o;
    o = '{irin, rin, rout, dinout, ain, gin, gout, addsub, done, t};
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(IRin, Rin, Rout, DINout, Ain, Gin, Gout, AddSub, Done, Tstep);
  endfunction

  function automatic logic [7:0] oh(input logic [2:0] c);
    logic [7:0] b;
    b = 8'h80;
    return b >> c;
  endfunction

  task automatic check_obs(input string name, input obs_t exp);
    obs_t got;
    got = sample();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got irin=%b rin=%h rout=%h dinout=%b ain=%b gin=%b gout=%b addsub=%b done=%b t=%0d ; want irin=%b rin=%h rout=%h dinout=%b ain=%b gin=%b gout=%b addsub=%b done=%b t=%0d",
               name, got.irin, got.rin, got.rout, got.dinout, got.ain, got.gin, got.gout,
               got.addsub, got.done, got.tstep, exp.irin, exp.rin, exp.rout, exp.dinout,
               exp.ain, exp.gin, exp.gout, exp.addsub, exp.done, exp.tstep);
    end
  endtask

  task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // Micro-op list for one fetched instruction, one entry per cycle after T0.
  task automatic load_plan(input logic [8:0] w);
    logic [2:0] op;
    logic [2:0] x;
    logic [2:0] y;
    op = w[8:6];
    x  = w[5:3];
    y  = w[2:0];
    plan.delete();
    case (op)
      3'b000: plan.push_back(mk(0, oh(x), oh(y), 0, 0, 0, 0, 0, 1, 2'd1));
      3'b001: plan.push_back(mk(0, oh(x), 8'h00, 1, 0, 0, 0, 0, 1, 2'd1));
      3'b010, 3'b011: begin
        plan.push_back(mk(0, 8'h00, oh(x), 0, 1, 0, 0, 0, 0, 2'd1));
        plan.push_back(mk(0, 8'h00, oh(y), 0, 0, 1, 0, op[0], 0, 2'd2));
        plan.push_back(mk(0, oh(x), 8'h00, 0, 0, 0, 1, 0, 1, 2'd3));
      end
      default: plan.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 2'd1));
    endcase
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1;
    Run   = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  obs_t zero;
  vec_t vec[19];

  initial begin
    zero  = '0;
    Reset = 1'b1;
    Run   = 1'b1;
    DIN   = 9'h0C5;

    // Reset held with Run=1: everything quiet, including IRin.
    @(negedge Clock);
    #1 check_obs("reset_hold_outputs", zero);
    check_val("reset_hold_ir", 16'(dut.ir), 16'h0);
    @(negedge Clock);
    #1 check_obs("reset_hold_outputs2", zero);
    Reset = 1'b0;
    #1 check_obs("reset_release_t0", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0));
    @(posedge Clock);
    #1;
    check_val("first_fetch_ir", 16'(dut.ir), 16'h0C5);
    check_val("first_fetch_tstep", 16'(Tstep), 16'd1);

    do_reset();

    // Directed cycle table, one row per clock starting in T0.
    vec[0]  = '{1, 9'b000_011_101, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0), "mv_fetch"};
    vec[1]  = '{0, 9'h000,         mk(0, 8'h10, 8'h04, 0, 0, 0, 0, 0, 1, 2'd1), "mv_r3_r5_t1"};
    vec[2]  = '{1, 9'b001_010_000, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0), "mvi_fetch"};
    vec[3]  = '{0, 9'h0A5,         mk(0, 8'h20, 8'h00, 1, 0, 0, 0, 0, 1, 2'd1), "mvi_r2_t1"};
    vec[4]  = '{1, 9'b011_001_110, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0), "sub_fetch"};
    vec[5]  = '{1, 9'h000,         mk(0, 8'h00, 8'h40, 0, 1, 0, 0, 0, 0, 2'd1), "sub_t1"};
    vec[6]  = '{1, 9'h000,         mk(0, 8'h00, 8'h02, 0, 0, 1, 0, 1, 0, 2'd2), "sub_t2"};
    vec[7]  = '{1, 9'b010_000_111, mk(0, 8'h40, 8'h00, 0, 0, 0, 1, 0, 1, 2'd3), "sub_t3"};
    vec[8]  = '{1, 9'b010_000_111, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0), "add_fetch_b2b"};
    vec[9]  = '{0, 9'h000,         mk(0, 8'h00, 8'h80, 0, 1, 0, 0, 0, 0, 2'd1), "add_t1_run_low"};
    vec[10] = '{0, 9'h000,         mk(0, 8'h00, 8'h01, 0, 0, 1, 0, 0, 0, 2'd2), "add_t2"};
    vec[11] = '{0, 9'h000,         mk(0, 8'h80, 8'h00, 0, 0, 0, 1, 0, 1, 2'd3), "add_t3"};
    vec[12] = '{0, 9'h000,         mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0), "idle_a"};
    vec[13] = '{0, 9'h1FF,         mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0), "idle_b"};
    vec[14] = '{1, 9'b111_000_000, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0), "nop_fetch"};
    vec[15] = '{1, 9'b000_011_011, mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 2'd1), "nop_t1"};
    vec[16] = '{1, 9'b000_011_011, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0), "mv_same_fetch"};
    vec[17] = '{0, 9'h000,         mk(0, 8'h10, 8'h10, 0, 0, 0, 0, 0, 1, 2'd1), "mv_r3_r3_t1"};
    vec[18] = '{0, 9'h000,         mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0), "back_to_t0"};

    for (int i = 0; i < 19; i++) begin
      @(negedge Clock);
      Run = vec[i].run;
      DIN = vec[i].din;
      #1 check_obs(vec[i].name, vec[i].exp);
    end

    // Reset pulsed in T2 of an add: controls drop at once, no Done afterwards.
    @(negedge Clock);
    Run = 1'b1;
    DIN = 9'b010_100_010;
    @(negedge Clock);
    Run = 1'b0;
    @(negedge Clock);
    #1 check_obs("rst_add_t2_before", mk(0, 8'h00, 8'h20, 0, 0, 1, 0, 0, 0, 2'd2));
    #1 Reset = 1'b1;
    #1 check_obs("rst_async_drop", zero);
    @(negedge Clock);
    Reset = 1'b0;
    #1 check_obs("rst_after_release", zero);
    check_val("rst_ir_cleared", 16'(dut.ir), 16'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      #1 check_obs("rst_no_done", zero);
    end

    // Randomized traffic against the micro-op list model.
    plan.delete();
    for (int c = 0; c < 600; c++) begin
      obs_t exp;
      @(negedge Clock);
      Run = ($urandom_range(0, 3) != 0);
      DIN = 9'($urandom);
      if (plan.size() == 0) exp = mk(Run, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0);
      else                  exp = plan[0];
      #1 check_obs("random", exp);
      n_checks++;
      if (($countones(Rout) + int'(DINout) + int'(Gout)) > 1) begin
        n_fail++;
        $display("FAIL bus_sources: got rout=%h dinout=%b gout=%b want at most one", Rout, DINout, Gout);
      end
      if (plan.size() == 0) begin
        if (Run) load_plan(DIN);
      end else begin
        void'(plan.pop_front());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
